// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one 16-bit execute ALU between
// the execute stage (req0) and the address/branch unit (req1).
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   reqN_valid/ready      request handshake, N = 0, 1
//   reqN_op/a/b           opcode and operands
//   reqN_cin/inva/invb/sign  ALU control bits
//   alu_*  (out)          registered opcode/operands/controls held on the ALU
//   alu_out/ofl/z/err     ALU result and flags
//   rsp_valid/ready       response handshake
//   rsp_id                requester owning the response
//   rsp_data/ofl/z/err    captured result and flags
//
// Parameter LAT (1..3): cycles the operands are held before sampling.
// Optional macro ALU_OPFILTER_EN: reject opcodes above 10000 with rsp_err=1.
module alu_share_arbiter #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req0_cin,
    input  logic        req0_inva,
    input  logic        req0_invb,
    input  logic        req0_sign,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_op,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic        req1_cin,
    input  logic        req1_inva,
    input  logic        req1_invb,
    input  logic        req1_sign,
    output logic [4:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_cin,
    output logic        alu_inva,
    output logic        alu_invb,
    output logic        alu_sign,
    input  logic [15:0] alu_out,
    input  logic        alu_ofl,
    input  logic        alu_z,
    input  logic        alu_err,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_ofl,
    output logic        rsp_z,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

    state_t      state;
    logic        last_grant;
    logic [1:0]  cnt;

    logic        gnt_any;
    logic        gnt_id;
    logic [4:0]  sel_op;
    logic [15:0] sel_a;
    logic [15:0] sel_b;
    logic        sel_cin;
    logic        sel_inva;
    logic        sel_invb;
    logic        sel_sign;
    logic        skip;

    // Grant is only offered in IDLE; on a tie the requester that did
    // not win last time goes first.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (state == IDLE) begin
            unique case (1'b1)
                req0_valid && req1_valid: begin
                    gnt_any = 1'b1;
                    gnt_id  = ~last_grant;
                end
                req0_valid && !req1_valid: begin
                    gnt_any = 1'b1;
                    gnt_id  = 1'b0;
                end
                !req0_valid && req1_valid: begin
                    gnt_any = 1'b1;
                    gnt_id  = 1'b1;
                end
                default: begin
                    gnt_any = 1'b0;
                    gnt_id  = 1'b0;
                end
            endcase
        end
    end

    assign req0_ready = gnt_any & ~gnt_id;
    assign req1_ready = gnt_any &  gnt_id;

    assign sel_op   = gnt_id ? req1_op   : req0_op;
    assign sel_a    = gnt_id ? req1_a    : req0_a;
    assign sel_b    = gnt_id ? req1_b    : req0_b;
    assign sel_cin  = gnt_id ? req1_cin  : req0_cin;
    assign sel_inva = gnt_id ? req1_inva : req0_inva;
    assign sel_invb = gnt_id ? req1_invb : req0_invb;
    assign sel_sign = gnt_id ? req1_sign : req0_sign;

`ifdef ALU_OPFILTER_EN
    // Legal set is 00000..10000, i.e. anything not above 16.
    assign skip = (sel_op > 5'd16);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= 2'd0;
            alu_op     <= 5'd0;
            alu_a      <= 16'd0;
            alu_b      <= 16'd0;
            alu_cin    <= 1'b0;
            alu_inva   <= 1'b0;
            alu_invb   <= 1'b0;
            alu_sign   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= 16'd0;
            rsp_ofl    <= 1'b0;
            rsp_z      <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_any) begin
                        rsp_id     <= gnt_id;
                        last_grant <= gnt_id;
                        if (skip) begin
                            // Rejected op: answer directly, ALU untouched.
                            rsp_data  <= 16'd0;
                            rsp_ofl   <= 1'b0;
                            rsp_z     <= 1'b0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            alu_op   <= sel_op;
                            alu_a    <= sel_a;
                            alu_b    <= sel_b;
                            alu_cin  <= sel_cin;
                            alu_inva <= sel_inva;
                            alu_invb <= sel_invb;
                            alu_sign <= sel_sign;
                            cnt      <= CNT_INIT;
                            state    <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 2'd0) begin
                        rsp_data  <= alu_out;
                        rsp_ofl   <= alu_ofl;
                        rsp_z     <= alu_z;
                        rsp_err   <= alu_err;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of alu_share_arbiter
// with LAT=1 (ux) and LAT=3 (uy) instances sharing the request stimulus.
module tb_alu_share_arbiter;

    localparam int LX = 1;
    localparam int LY = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v0, v1;
    logic [4:0]  op0, op1;
    logic [15:0] a0, b0, a1, b1;
    logic        cin0, inva0, invb0, sign0;
    logic        cin1, inva1, invb1, sign1;
    logic        rsp_ready;

    logic        x_r0, x_r1, x_cin, x_inva, x_invb, x_sign;
    logic [4:0]  x_op;
    logic [15:0] x_a, x_b, x_out, x_rd;
    logic        x_ofl, x_z, x_err, x_rv, x_rid, x_rofl, x_rz, x_rerr;

    logic        y_r0, y_r1, y_cin, y_inva, y_invb, y_sign;
    logic [4:0]  y_op;
    logic [15:0] y_a, y_b, y_out, y_rd;
    logic        y_ofl, y_z, y_err, y_rv, y_rid, y_rofl, y_rz, y_rerr;

    int checks = 0;
    int errors = 0;

    // Behavioural ALU: returns {ofl, z, err, result}.
    function automatic logic [18:0] alu_fn(
        input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
        input logic cin, input logic inva, input logic invb, input logic sgn);
        logic [15:0] aa, bb, r;
        logic [16:0] s;
        logic        ofl;
        aa  = inva ? ~a : a;
        bb  = invb ? ~b : b;
        ofl = 1'b0;
        case (op)
            5'd4: begin
                s = {1'b0, aa} + {1'b0, bb} + {16'd0, cin};
                r = s[15:0];
                ofl = sgn ? ((aa[15] == bb[15]) && (r[15] != aa[15])) : s[16];
            end
            5'd5:    r = aa | bb;
            5'd6:    r = aa & bb;
            5'd7:    r = aa ^ bb;
            default: r = aa - bb + {11'd0, op};
        endcase
        return {ofl, (r == 16'd0), (op == 5'd31), r};
    endfunction

    assign {x_ofl, x_z, x_err, x_out} =
        alu_fn(x_op, x_a, x_b, x_cin, x_inva, x_invb, x_sign);
    assign {y_ofl, y_z, y_err, y_out} =
        alu_fn(y_op, y_a, y_b, y_cin, y_inva, y_invb, y_sign);

    alu_share_arbiter #(.LAT(LX)) ux (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(x_r0), .req0_op(op0),
        .req0_a(a0), .req0_b(b0), .req0_cin(cin0), .req0_inva(inva0),
        .req0_invb(invb0), .req0_sign(sign0),
        .req1_valid(v1), .req1_ready(x_r1), .req1_op(op1),
        .req1_a(a1), .req1_b(b1), .req1_cin(cin1), .req1_inva(inva1),
        .req1_invb(invb1), .req1_sign(sign1),
        .alu_op(x_op), .alu_a(x_a), .alu_b(x_b), .alu_cin(x_cin),
        .alu_inva(x_inva), .alu_invb(x_invb), .alu_sign(x_sign),
        .alu_out(x_out), .alu_ofl(x_ofl), .alu_z(x_z), .alu_err(x_err),
        .rsp_valid(x_rv), .rsp_ready(rsp_ready), .rsp_id(x_rid),
        .rsp_data(x_rd), .rsp_ofl(x_rofl), .rsp_z(x_rz), .rsp_err(x_rerr)
    );

    alu_share_arbiter #(.LAT(LY)) uy (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(y_r0), .req0_op(op0),
        .req0_a(a0), .req0_b(b0), .req0_cin(cin0), .req0_inva(inva0),
        .req0_invb(invb0), .req0_sign(sign0),
        .req1_valid(v1), .req1_ready(y_r1), .req1_op(op1),
        .req1_a(a1), .req1_b(b1), .req1_cin(cin1), .req1_inva(inva1),
        .req1_invb(invb1), .req1_sign(sign1),
        .alu_op(y_op), .alu_a(y_a), .alu_b(y_b), .alu_cin(y_cin),
        .alu_inva(y_inva), .alu_invb(y_invb), .alu_sign(y_sign),
        .alu_out(y_out), .alu_ofl(y_ofl), .alu_z(y_z), .alu_err(y_err),
        .rsp_valid(y_rv), .rsp_ready(rsp_ready), .rsp_id(y_rid),
        .rsp_data(y_rd), .rsp_ofl(y_rofl), .rsp_z(y_rz), .rsp_err(y_rerr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        v0 = 0; v1 = 0; op0 = 0; op1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        cin0 = 0; inva0 = 0; invb0 = 0; sign0 = 0;
        cin1 = 0; inva1 = 0; invb1 = 0; sign1 = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int          gid[$];
    int          gcyc[$];
    int          cyc;
    int          hs_cyc;
    logic        busy, lastg, skip, exp_rv, g_any, g;
    logic        e_id;
    logic [18:0] e_res;
    logic [4:0]  e_op;
    logic [15:0] e_a, e_b;

    initial begin
        clear_inputs();
        rsp_ready = 1'b1;
        do_reset();

        // Reset state
        chk("rst_rsp_valid", x_rv, 0);
        chk("rst_rsp_id", x_rid, 0);
        chk("rst_rsp_data", x_rd, 0);
        chk("rst_rsp_err", x_rerr, 0);
        chk("rst_alu_op", x_op, 0);
        chk("rst_alu_a", x_a, 0);
        chk("rst_ready0", x_r0, 0);
        chk("rst_ready1", x_r1, 0);

        // Single add on req0
        v0 = 1; op0 = 5'd4; a0 = 16'h0003; b0 = 16'h0004;
        #1;
        chk("t1_ready0", x_r0, 1);
        chk("t1_ready1", x_r1, 0);
        @(negedge clk);
        v0 = 0;
        chk("t1_alu_a", x_a, 16'h0003);
        chk("t1_alu_op", x_op, 5'd4);
        chk("t1_rv_early", x_rv, 0);
        @(negedge clk);
        chk("t1_rv", x_rv, 1);
        chk("t1_rid", x_rid, 0);
        chk("t1_rd", x_rd, 16'h0007);
        @(negedge clk);
        chk("t1_rv_done", x_rv, 0);

        // Both requesters always valid: alternating grants, one per 3 cycles
        do_reset();
        v0 = 1; v1 = 1; op0 = 5'd5; op1 = 5'd6;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (x_r0 || x_r1) begin
                gid.push_back(x_r1 ? 1 : 0);
                gcyc.push_back(i);
            end
            @(negedge clk);
        end
        v0 = 0; v1 = 0;
        chk("t2_ngrants", gid.size(), 4);
        for (int i = 0; i < 4 && i < gid.size(); i++) begin
            chk("t2_grant_id", gid[i], i % 2);
            chk("t2_grant_cyc", gcyc[i], 3 * i);
        end

        // Response stall
        do_reset();
        rsp_ready = 0;
        v0 = 1; op0 = 5'd4; a0 = 16'h1111; b0 = 16'h2222;
        @(negedge clk);
        v1 = 1; op1 = 5'd7;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t3_rv", x_rv, 1);
            chk("t3_rd", x_rd, 16'h3333);
            chk("t3_rid", x_rid, 0);
            chk("t3_ready0", x_r0, 0);
            chk("t3_ready1", x_r1, 0);
            @(negedge clk);
        end
        rsp_ready = 1;
        @(negedge clk);
        chk("t3_rv_done", x_rv, 0);
        chk("t3_idle_ready1", x_r1, 1);
        chk("t3_idle_ready0", x_r0, 0);
        v0 = 0; v1 = 0;

        // Reset during EXEC discards the op
        v1 = 1; op1 = 5'd4; a1 = 16'h0001; b1 = 16'h0001;
        #1;
        chk("t4_ready1", x_r1, 1);
        @(negedge clk);
        v1 = 0;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            chk("t4_no_rv", x_rv, 0);
            @(negedge clk);
        end
        v0 = 1; v1 = 1;
        #1;
        chk("t4_ready0", x_r0, 1);
        chk("t4_ready1", x_r1, 0);
        v0 = 0; v1 = 0;
        @(negedge clk);

        // Opcode 11111 from req1
        v1 = 1; op1 = 5'd31; a1 = 16'h0005; b1 = 16'h0003;
        #1;
        chk("t5_ready1", x_r1, 1);
        @(negedge clk);
        v1 = 0;
`ifdef ALU_OPFILTER_EN
        chk("t5_rv", x_rv, 1);
        chk("t5_rerr", x_rerr, 1);
        chk("t5_rd", x_rd, 0);
        chk("t5_alu_op", x_op, 0);
`else
        chk("t5_alu_op", x_op, 5'd31);
        @(negedge clk);
        chk("t5_rv", x_rv, 1);
        chk("t5_rerr", x_rerr, 1);
        chk("t5_rid", x_rid, 1);
`endif
        @(negedge clk);

        // LAT=3 instance
        do_reset();
        v0 = 1; op0 = 5'd5; a0 = 16'h00F0; b0 = 16'h000F;
        #1;
        chk("t6_ready0", y_r0, 1);
        @(negedge clk);
        v0 = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_alu_a", y_a, 16'h00F0);
            chk("t6_alu_op", y_op, 5'd5);
            chk("t6_rv_early", y_rv, 0);
            @(negedge clk);
        end
        chk("t6_rv", y_rv, 1);
        chk("t6_rd", y_rd, 16'h00FF);
        chk("t6_rid", y_rid, 0);

        // Randomized traffic on the LAT=1 instance against a
        // transaction-level model.
        clear_inputs();
        do_reset();
        busy = 0; lastg = 1; skip = 0; cyc = 0; hs_cyc = 0;
        e_id = 0; e_res = 0; e_op = 0; e_a = 0; e_b = 0;
        for (int i = 0; i < 600; i++) begin
            exp_rv = busy && (cyc >= hs_cyc + (skip ? 1 : LX));
            chk("rnd_rv", x_rv, exp_rv);
            if (exp_rv) begin
                chk("rnd_rid", x_rid, e_id);
                chk("rnd_rd", x_rd, skip ? 16'd0 : e_res[15:0]);
                chk("rnd_rofl", x_rofl, skip ? 1'b0 : e_res[18]);
                chk("rnd_rz", x_rz, skip ? 1'b0 : e_res[17]);
                chk("rnd_rerr", x_rerr, skip ? 1'b1 : e_res[16]);
            end
            if (busy && !skip) begin
                chk("rnd_alu_op", x_op, e_op);
                chk("rnd_alu_a", x_a, e_a);
                chk("rnd_alu_b", x_b, e_b);
            end
            v0 = ($urandom_range(0, 2) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            op0 = 5'($urandom_range(0, 31));
            op1 = 5'($urandom_range(0, 31));
            a0 = 16'($urandom); b0 = 16'($urandom);
            a1 = 16'($urandom); b1 = 16'($urandom);
            {cin0, inva0, invb0, sign0} = 4'($urandom);
            {cin1, inva1, invb1, sign1} = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g_any = !busy && (v0 || v1);
            g = (v0 && v1) ? !lastg : v1;
            chk("rnd_ready0", x_r0, g_any && !g);
            chk("rnd_ready1", x_r1, g_any && g);
            if (exp_rv && rsp_ready) begin
                busy = 0;
            end else if (g_any) begin
                busy = 1;
                hs_cyc = cyc + 1;
                lastg = g;
                e_id = g;
                e_op = g ? op1 : op0;
                e_a = g ? a1 : a0;
                e_b = g ? b1 : b0;
                e_res = g ? alu_fn(op1, a1, b1, cin1, inva1, invb1, sign1)
                          : alu_fn(op0, a0, b0, cin0, inva0, invb0, sign0);
`ifdef ALU_OPFILTER_EN
                skip = (e_op > 5'd16);
`else
                skip = 0;
`endif
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
